dfi_phy_responder: RTL and testbench

- PHY-side DFI responder for the DDR4 controller: the far end of the controller's DFI interface, used as a loopback PHY model in block-level simulation and FPGA bring-up.
- Fixed 1:4 frequency ratio (phases p0..p3), single `dfi_clk` domain.
- Write beats are stored in a phase-ordered circular buffer and returned on later reads after a fixed read latency.
- Also sequences `dfi_init_complete`, answers controller update requests, and flags buffer overflow/underflow on `dfi_error`.

---
 rtl/dfi_phy_responder.sv | 175 +++++++++++++++++
 tb/tb_dfi_phy_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dfi_phy_responder.sv
// Loopback DFI PHY model at a 1:4 ratio: buffers write beats in phase order and
// replays them on reads after RD_LAT cycles, plus init sequencing and update handshake.
module dfi_phy_responder #(
  parameter int DFI_DATA_WIDTH = 128,
  parameter int DEPTH          = 64,
  parameter int RD_LAT         = 6,
  parameter int INIT_CYCLES    = 16,
  parameter int UPD_ACK_DLY    = 2
) (
  input  logic                          dfi_clk,
  input  logic                          reset,
  input  logic [3:0]                    dfi_wrdata_en,
  input  logic [4*DFI_DATA_WIDTH-1:0]   dfi_wrdata,
  input  logic [3:0]                    dfi_rddata_en,
  output logic [4*DFI_DATA_WIDTH-1:0]   dfi_rddata,
  output logic [3:0]                    dfi_rddata_valid,
  input  logic                          dfi_ctrlupd_req,
  output logic                          dfi_ctrlupd_ack,
  output logic                          dfi_init_complete,
  output logic                          dfi_error,
  output logic [1:0]                    dfi_error_info,
  output logic [$clog2(DEPTH):0]        fill_level
);
  localparam int W  = DFI_DATA_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int UW = $clog2(UPD_ACK_DLY + 1);
  localparam logic [UW-1:0] UPD_LOAD = UW'((UPD_ACK_DLY > 1) ? UPD_ACK_DLY - 2 : 0);

  logic [IW-1:0] init_cnt;
  logic          init_done;

  always_ff @(posedge dfi_clk or posedge reset) begin
    if (reset) begin
      init_cnt  <= IW'(INIT_CYCLES - 1);
      init_done <= 1'b0;
    end else if (!init_done) begin
      if (init_cnt == '0) init_done <= 1'b1;
      else                init_cnt  <= init_cnt - 1'b1;
    end
  end

  assign dfi_init_complete = init_done;

  logic [W-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [3:0]      wr_en, rd_en, wr_acc;
  logic [AW-1:0]   wr_addr [4];
  logic [2:0]      wr_k, rd_k;
  logic [CW-1:0]   free_cnt;
  logic [4*W-1:0]  rd_data;
  logic [AW-1:0]   rd_addr;
  logic            ovf, unf;

  assign wr_en    = dfi_wrdata_en & {4{init_done}};
  assign rd_en    = dfi_rddata_en & {4{init_done}};
  assign free_cnt = CW'(DEPTH) - fill_level;

  // Phases are ranked in p0..p3 order; the k-th enabled phase lands at ptr+k,
  // and both push and pop limits use the occupancy at the start of the cycle.
  always_comb begin
    wr_k    = '0;
    rd_k    = '0;
    wr_acc  = '0;
    ovf     = 1'b0;
    unf     = 1'b0;
    rd_data = '0;
    rd_addr = '0;
    for (int i = 0; i < 4; i++) begin
      wr_addr[i] = wr_ptr + AW'(wr_k);
      if (wr_en[i]) begin
        if (CW'(wr_k) < free_cnt) begin
          wr_acc[i] = 1'b1;
          wr_k      = wr_k + 3'd1;
        end else begin
          ovf = 1'b1;
        end
      end
      if (rd_en[i]) begin
        if (CW'(rd_k) < fill_level) begin
          rd_addr           = rd_ptr + AW'(rd_k);
          rd_data[i*W +: W] = mem[rd_addr];
          rd_k              = rd_k + 3'd1;
        end else begin
          unf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge dfi_clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_acc[i]) mem[wr_addr[i]] <= dfi_wrdata[i*W +: W];
  end

  logic [3:0]     vld_pipe [RD_LAT];
  logic [4*W-1:0] dat_pipe [RD_LAT];

  always_ff @(posedge dfi_clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      dfi_error      <= 1'b0;
      dfi_error_info <= 2'b00;
      for (int s = 0; s < RD_LAT; s++) begin
        vld_pipe[s] <= '0;
        dat_pipe[s] <= '0;
      end
    end else begin
      wr_ptr         <= wr_ptr + AW'(wr_k);
      rd_ptr         <= rd_ptr + AW'(rd_k);
      fill_level     <= fill_level + CW'(wr_k) - CW'(rd_k);
      dfi_error      <= ovf | unf;
      dfi_error_info <= {unf, ovf};
      vld_pipe[0]    <= rd_en;
      dat_pipe[0]    <= rd_data;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign dfi_rddata_valid = vld_pipe[RD_LAT-1];
  assign dfi_rddata       = dat_pipe[RD_LAT-1];

  // state    | meaning
  // UPD_IDLE | no request pending
  // UPD_WAIT | request seen, counting down to ack; request drop aborts silently
  // UPD_ACK  | ack held until the request drops
  typedef enum logic [1:0] {UPD_IDLE, UPD_WAIT, UPD_ACK} upd_state_t;

  upd_state_t    upd_state, upd_next;
  logic [UW-1:0] upd_cnt, upd_cnt_next;

  always_ff @(posedge dfi_clk or posedge reset) begin
    if (reset) begin
      upd_state <= UPD_IDLE;
      upd_cnt   <= '0;
    end else begin
      upd_state <= upd_next;
      upd_cnt   <= upd_cnt_next;
    end
  end

  always_comb begin
    upd_next     = upd_state;
    upd_cnt_next = upd_cnt;
    case (upd_state)
      UPD_IDLE:
        if (dfi_ctrlupd_req) begin
          if (UPD_ACK_DLY == 1) begin
            upd_next = UPD_ACK;
          end else begin
            upd_next     = UPD_WAIT;
            upd_cnt_next = UPD_LOAD;
          end
        end
      UPD_WAIT:
        if (!dfi_ctrlupd_req)  upd_next     = UPD_IDLE;
        else if (upd_cnt == '0) upd_next    = UPD_ACK;
        else                   upd_cnt_next = upd_cnt - 1'b1;
      UPD_ACK:
        if (!dfi_ctrlupd_req) upd_next = UPD_IDLE;
      default: upd_next = UPD_IDLE;
    endcase
  end

  always_comb begin
    dfi_ctrlupd_ack = (upd_state == UPD_ACK);
  end

endmodule

// File: tb/tb_dfi_phy_responder.sv
// Directed bench for dfi_phy_responder: stimulus queues expected read/error responses,
// a negedge monitor pops and compares them when the DUT presents valid or error.
module tb_dfi_phy_responder;
  localparam int W      = 32;
  localparam int DEPTH  = 64;
  localparam int RD_LAT = 6;
  localparam int CW     = 7;

  logic            dfi_clk = 1'b0;
  logic            reset   = 1'b1;
  logic [3:0]      dfi_wrdata_en = '0;
  logic [4*W-1:0]  dfi_wrdata    = '0;
  logic [3:0]      dfi_rddata_en = '0;
  logic [4*W-1:0]  dfi_rddata;
  logic [3:0]      dfi_rddata_valid;
  logic            dfi_ctrlupd_req = 1'b0;
  logic            dfi_ctrlupd_ack;
  logic            dfi_init_complete;
  logic            dfi_error;
  logic [1:0]      dfi_error_info;
  logic [CW-1:0]   fill_level;

  dfi_phy_responder #(
    .DFI_DATA_WIDTH(W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .INIT_CYCLES(16), .UPD_ACK_DLY(2)
  ) dut (
    .dfi_clk(dfi_clk), .reset(reset),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata),
    .dfi_rddata_en(dfi_rddata_en), .dfi_rddata(dfi_rddata), .dfi_rddata_valid(dfi_rddata_valid),
    .dfi_ctrlupd_req(dfi_ctrlupd_req), .dfi_ctrlupd_ack(dfi_ctrlupd_ack),
    .dfi_init_complete(dfi_init_complete), .dfi_error(dfi_error),
    .dfi_error_info(dfi_error_info), .fill_level(fill_level)
  );

  always #5 dfi_clk = ~dfi_clk;

  int cyc = 0;
  always @(posedge dfi_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; logic [3:0] mask; logic [4*W-1:0] data; } rd_exp_t;
  typedef struct { int due; logic [1:0] info; } err_exp_t;
  rd_exp_t  rd_q[$];
  err_exp_t err_q[$];
  rd_exp_t  me;
  err_exp_t ee;

  always @(negedge dfi_clk) begin
    if (!reset) begin
      if (rd_q.size() != 0 && rd_q[0].due < cyc) begin
        me = rd_q.pop_front();
        checks++; errors++;
        $display("FAIL rd_missing cyc=%0d due=%0d mask=%b", cyc, me.due, me.mask);
      end
      if (dfi_rddata_valid != 4'b0) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected cyc=%0d valid=%b data=%h", cyc, dfi_rddata_valid, dfi_rddata);
        end else begin
          me = rd_q.pop_front();
          if (cyc != me.due || dfi_rddata_valid != me.mask || dfi_rddata !== me.data) begin
            errors++;
            $display("FAIL rd_data cyc=%0d/%0d valid=%b/%b data=%h expected %h",
                     cyc, me.due, dfi_rddata_valid, me.mask, dfi_rddata, me.data);
          end
        end
      end
      if (err_q.size() != 0 && err_q[0].due < cyc) begin
        ee = err_q.pop_front();
        checks++; errors++;
        $display("FAIL err_missing cyc=%0d due=%0d info=%b", cyc, ee.due, ee.info);
      end
      if (dfi_error) begin
        checks++;
        if (err_q.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected cyc=%0d info=%b", cyc, dfi_error_info);
        end else begin
          ee = err_q.pop_front();
          if (cyc != ee.due || dfi_error_info != ee.info) begin
            errors++;
            $display("FAIL err_info cyc=%0d/%0d info=%b expected %b", cyc, ee.due, dfi_error_info, ee.info);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [4*W-1:0] p4(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] pat(input int j);
    return 32'h1000_0000 + W'(j);
  endfunction

  task automatic tick();
    @(posedge dfi_clk); #1;
  endtask

  task automatic drive(input logic [3:0] we, input logic [4*W-1:0] wd, input logic [3:0] re);
    dfi_wrdata_en = we; dfi_wrdata = wd; dfi_rddata_en = re;
    tick();
    dfi_wrdata_en = '0; dfi_wrdata = '0; dfi_rddata_en = '0;
  endtask

  task automatic exp_rd(input logic [3:0] mask, input logic [4*W-1:0] data);
    rd_exp_t e;
    e.due = cyc + RD_LAT; e.mask = mask; e.data = data;
    rd_q.push_back(e);
  endtask

  task automatic exp_err(input logic [1:0] info);
    err_exp_t e;
    e.due = cyc + 1; e.info = info;
    err_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rd_q.size() != 0 || err_q.size() != 0); i++) tick();
    check("drain_rd", rd_q.size(), 0);
    check("drain_err", err_q.size(), 0);
  endtask

  logic [W-1:0] ow [64];

  initial begin
    repeat (3) tick();
    check("reset_fill", 32'(fill_level), 0);
    check("reset_valid", 32'(dfi_rddata_valid), 0);
    check("reset_init", 32'(dfi_init_complete), 0);
    reset = 1'b0;

    // init: enables at cycle 10 are ignored, complete from cycle 16
    repeat (10) tick();
    check("init_c10", 32'(dfi_init_complete), 0);
    drive(4'b1111, p4(32'h11, 32'h22, 32'h33, 32'h44), 4'b1111);
    check("init_nopush", 32'(fill_level), 0);
    repeat (4) tick();
    check("init_c15", 32'(dfi_init_complete), 0);
    tick();
    check("init_c16", 32'(dfi_init_complete), 1);

    // basic loopback
    drive(4'b1111, p4(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004), 4'b0000);
    check("basic_fill4", 32'(fill_level), 4);
    exp_rd(4'b1111, p4(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004));
    drive(4'b0000, '0, 4'b1111);
    check("basic_fill0", 32'(fill_level), 0);
    drain();

    // advance pointers to 62, then sparse groups straddle the wrap
    for (int g = 0; g < 14; g++)
      drive(4'b1111, p4(pat(4*g), pat(4*g+1), pat(4*g+2), pat(4*g+3)), 4'b0000);
    drive(4'b0011, p4(pat(56), pat(57), '0, '0), 4'b0000);
    check("wrap_fill58", 32'(fill_level), 58);
    for (int g = 0; g < 14; g++) begin
      exp_rd(4'b1111, p4(pat(4*g), pat(4*g+1), pat(4*g+2), pat(4*g+3)));
      drive(4'b0000, '0, 4'b1111);
    end
    exp_rd(4'b0011, p4(pat(56), pat(57), '0, '0));
    drive(4'b0000, '0, 4'b0011);
    check("wrap_fill0", 32'(fill_level), 0);
    drive(4'b1010, p4('0, 32'hAAAA_0001, '0, 32'hBBBB_0001), 4'b0000);
    drive(4'b1010, p4('0, 32'hAAAA_0002, '0, 32'hBBBB_0002), 4'b0000);
    check("wrap_fill4", 32'(fill_level), 4);
    exp_rd(4'b0101, p4(32'hAAAA_0001, '0, 32'hBBBB_0001, '0));
    drive(4'b0000, '0, 4'b0101);
    exp_rd(4'b0101, p4(32'hAAAA_0002, '0, 32'hBBBB_0002, '0));
    drive(4'b0000, '0, 4'b0101);
    check("wrap_fill_end", 32'(fill_level), 0);
    drain();

    // overflow at 62 of 64
    for (int j = 0; j < 62; j++) ow[j] = pat(100 + j);
    ow[62] = 32'hEEEE_0000; ow[63] = 32'hFFFF_0000;
    for (int g = 0; g < 15; g++)
      drive(4'b1111, p4(ow[4*g], ow[4*g+1], ow[4*g+2], ow[4*g+3]), 4'b0000);
    drive(4'b0011, p4(ow[60], ow[61], '0, '0), 4'b0000);
    check("ovf_fill62", 32'(fill_level), 62);
    exp_err(2'b01);
    drive(4'b1111, p4(32'hEEEE_0000, 32'hFFFF_0000, 32'h6666_0000, 32'h7777_0000), 4'b0000);
    check("ovf_fill64", 32'(fill_level), 64);
    for (int g = 0; g < 16; g++) begin
      exp_rd(4'b1111, p4(ow[4*g], ow[4*g+1], ow[4*g+2], ow[4*g+3]));
      drive(4'b0000, '0, 4'b1111);
    end
    check("ovf_fill0", 32'(fill_level), 0);
    drain();

    // underflow with same-cycle push
    drive(4'b0001, p4(32'h2222_0000, '0, '0, '0), 4'b0000);
    check("unf_fill1", 32'(fill_level), 1);
    exp_rd(4'b0011, p4(32'h2222_0000, '0, '0, '0));
    exp_err(2'b10);
    drive(4'b1111, p4(32'h5500_0000, 32'h5500_0001, 32'h5500_0002, 32'h5500_0003), 4'b0011);
    check("unf_fill4", 32'(fill_level), 4);
    exp_rd(4'b1111, p4(32'h5500_0000, 32'h5500_0001, 32'h5500_0002, 32'h5500_0003));
    drive(4'b0000, '0, 4'b1111);
    check("unf_fill0", 32'(fill_level), 0);
    drain();

    // update handshake: held 5 cycles, then a 1-cycle request
    dfi_ctrlupd_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) dfi_ctrlupd_req = 1'b0;
      check($sformatf("upd_ack_k%0d", k), 32'(dfi_ctrlupd_ack), (k >= 2 && k <= 5) ? 1 : 0);
      tick();
    end
    dfi_ctrlupd_req = 1'b1;
    tick();
    dfi_ctrlupd_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("upd_short_noack", 32'(dfi_ctrlupd_ack), 0);
      tick();
    end

    // reset with reads in flight
    for (int g = 0; g < 3; g++)
      drive(4'b1111, p4(pat(200+4*g), pat(201+4*g), pat(202+4*g), pat(203+4*g)), 4'b0000);
    for (int g = 0; g < 3; g++) drive(4'b0000, '0, 4'b1111);
    reset = 1'b1;
    tick();
    check("rst_fill", 32'(fill_level), 0);
    check("rst_valid", 32'(dfi_rddata_valid), 0);
    check("rst_init", 32'(dfi_init_complete), 0);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("rst_novalid", 32'(dfi_rddata_valid), 0);
      tick();
    end
    check("rst_reinit", 32'(dfi_init_complete), 1);
    check("rst_fill_after", 32'(fill_level), 0);
    drive(4'b1111, p4(32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 32'h9000_0004), 4'b0000);
    exp_rd(4'b1111, p4(32'h9000_0001, 32'h9000_0002, 32'h9000_0003, 32'h9000_0004));
    drive(4'b0000, '0, 4'b1111);
    drain();
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
